lfsr_keystream_ctrl: RTL
========================

LFSR_KEYSTREAM_CTRL -- requirements
Module: lfsr_keystream_ctrl

Interface
REQ-001 SHALL have parameter WORD_W, default 8, output word width in keystream bits (1..32).
REQ-002 SHALL have parameter WARMUP, default 64, LFSR steps discarded after each seed load (0..1023).
REQ-003 SHALL have parameter CNT_W, default 16, width of the word-count request.
REQ-004 SHALL have port i_clk, input, 1, sole clock.
REQ-005 SHALL have port i_rst, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port i_start, input, 1, request to begin a keystream job.
REQ-007 SHALL have port i_seed, input, 64, job seed, sampled with i_start.
REQ-008 SHALL have port i_nwords, input, CNT_W, words to produce, sampled with i_start.
REQ-009 SHALL have port i_abort, input, 1, synchronous job cancel.
REQ-010 SHALL have port o_lfsr_load, output, 1, one-cycle load strobe to the LFSR.
REQ-011 SHALL have port o_lfsr_seed, output, 64, seed presented to the LFSR.
REQ-012 SHALL have port o_lfsr_step, output, 1, LFSR advance enable.
REQ-013 SHALL have port i_lfsr_bit, input, 1, LFSR keystream bit for its current state.
REQ-014 SHALL have port o_word, output, WORD_W, packed keystream word.
REQ-015 SHALL have port o_valid, output, 1, o_word valid.
REQ-016 SHALL have port i_ready, input, 1, consumer accepts o_word.
REQ-017 SHALL have ports o_busy (output, 1, job active) and o_done (output, 1, one-cycle job-complete pulse).

Function
REQ-018 SHALL implement FSM states IDLE, LOAD, WARMUP, RUN, HOLD, DONE; o_busy=1 in every state except IDLE.
REQ-019 In IDLE, i_start=1 with i_nwords!=0 SHALL latch i_seed and i_nwords and go to LOAD; i_start with i_nwords=0 SHALL go to DONE without loading.
REQ-020 i_start SHALL be ignored in every state except IDLE.
REQ-021 LOAD SHALL last one cycle with o_lfsr_load=1 and o_lfsr_seed=latched seed, then go to WARMUP (or to RUN if WARMUP=0).
REQ-022 WARMUP SHALL assert o_lfsr_step for exactly WARMUP consecutive cycles, discard i_lfsr_bit, then go to RUN.
REQ-023 RUN SHALL assert o_lfsr_step every cycle and shift i_lfsr_bit, sampled in the same cycle, into the word, first bit ending in o_word[WORD_W-1].
REQ-024 After WORD_W RUN bits, the word SHALL be registered to o_word with o_valid=1 and state HOLD; o_lfsr_step=0 in HOLD.
REQ-025 o_valid and o_word SHALL hold stable until o_valid&&i_ready; on that handshake the remaining count SHALL decrement and state SHALL go to RUN, or to DONE if the count reaches 0.
REQ-026 First o_valid SHALL rise WARMUP+WORD_W+1 clock edges after the edge that samples i_start.
REQ-027 DONE SHALL last one cycle with o_done=1, then go to IDLE.
REQ-028 i_abort=1 in any non-IDLE state SHALL return the FSM to IDLE next edge, clear o_valid and o_lfsr_step, and produce no o_done; i_abort SHALL take priority over a simultaneous handshake.
REQ-029 o_lfsr_load and o_lfsr_step SHALL never be asserted in the same cycle.

Reset
REQ-030 i_rst=0 SHALL asynchronously force IDLE, o_lfsr_load=0, o_lfsr_step=0, o_lfsr_seed=0, o_word=0, o_valid=0, o_busy=0, o_done=0, and clear counters.
REQ-031 Reset deassertion SHALL take effect at the next i_clk edge, with no output glitch.

Configuration
REQ-032 Macro LFSR_KEYSTREAM_ZERO_SEED_GUARD_EN defined: a latched seed of 64'h0 SHALL be replaced by 64'h0000_0000_0000_0001 on o_lfsr_seed; undefined: seed SHALL pass through unchanged, including zero.

Verification
REQ-033 Reset during RUN (i_rst=0 mid-word) -> all outputs 0 immediately, FSM IDLE.
REQ-034 WARMUP=4, WORD_W=8, i_nwords=2, i_ready=1, LFSR model fed i_seed=64'h1 -> 4 discarded steps, 2 words matching the model's next 16 bits MSB-first, o_done one cycle after the second handshake, first o_valid 13 edges after start.
REQ-035 i_nwords=0 with i_start -> no o_lfsr_load, o_done on the next cycle, o_busy high for one cycle.
REQ-036 i_ready=0 for 10 cycles in HOLD -> o_word stable, o_lfsr_step=0 throughout, no bit lost after release.
REQ-037 i_abort in the same cycle as o_valid&&i_ready -> IDLE next edge, o_valid=0, no o_done, count not decremented.
REQ-038 i_seed=0 with the guard macro defined -> o_lfsr_seed=64'h1 during LOAD; without the macro -> 64'h0.

Source files
------------

// File: rtl/lfsr_keystream_ctrl.sv
// lfsr_keystream_ctrl
//   Controls an external 64-bit LFSR. It loads a seed, discards WARMUP steps,
//   then packs keystream bits into WORD_W-bit words and hands each word to a
//   consumer. A job produces i_nwords words.
//
// Handshake: o_valid/i_ready. A word transfers on any rising edge where
//   o_valid && i_ready. Once o_valid rises, o_word and o_valid stay stable
//   until that transfer or an abort. i_ready may change freely.
//
// Ports
//   i_clk, i_rst        clock, asynchronous active-low reset
//   i_start, i_seed,    job request; seed and word count are sampled with it
//   i_nwords
//   i_abort             synchronous job cancel (no o_done)
//   o_lfsr_load,        one-cycle seed load strobe and the seed to load
//   o_lfsr_seed
//   o_lfsr_step         LFSR advance enable
//   i_lfsr_bit          keystream bit of the LFSR's current state
//   o_word, o_valid,    output word stream
//   i_ready
//   o_busy, o_done      job active, one-cycle completion pulse
//   o_state             FSM state for debug
//                       (0 IDLE, 1 LOAD, 2 WARMUP, 3 RUN, 4 HOLD, 5 DONE)
//
// Configuration macro: LFSR_KEYSTREAM_ZERO_SEED_GUARD_EN
//   When defined, a zero seed is replaced by 64'h1 because an all-zero LFSR
//   state would lock up. The substitution is made when the seed is latched,
//   so o_lfsr_seed still reads 0 while the block is in reset.
module lfsr_keystream_ctrl #(
  parameter int WORD_W = 8,
  parameter int WARMUP = 64,
  parameter int CNT_W  = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [63:0]       i_seed,
  input  logic [CNT_W-1:0]  i_nwords,
  input  logic              i_abort,
  output logic              o_lfsr_load,
  output logic [63:0]       o_lfsr_seed,
  output logic              o_lfsr_step,
  input  logic              i_lfsr_bit,
  output logic [WORD_W-1:0] o_word,
  output logic              o_valid,
  input  logic              i_ready,
  output logic              o_busy,
  output logic              o_done,
  output logic [2:0]        o_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_WARMUP = 3'd2,
    S_RUN    = 3'd3,
    S_HOLD   = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  localparam int BIT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(WORD_W - 1);
  localparam logic [9:0]       WARM_LAST = (WARMUP > 0) ? 10'(WARMUP - 1) : 10'd0;

  state_t             state, state_nxt;
  logic [63:0]        seed_q;
  logic [63:0]        seed_latch;
  logic [CNT_W-1:0]   words_left;
  logic [9:0]         warm_cnt;
  logic [BIT_W-1:0]   bit_cnt;
  logic [WORD_W-1:0]  shift_nxt;
  logic [WORD_W-1:0]  word_q;
  logic               valid_q;
  logic               abort_go;

  // Abort only has an effect on an active job. In HOLD it overrides a
  // simultaneous handshake because it is evaluated first.
  assign abort_go = i_abort && (state != S_IDLE);

`ifdef LFSR_KEYSTREAM_ZERO_SEED_GUARD_EN
  assign seed_latch = (i_seed == 64'h0) ? 64'h1 : i_seed;
`else
  assign seed_latch = i_seed;
`endif

  // Shift register holds the bits gathered so far. Its oldest bit lands in
  // the MSB of the finished word on the last RUN cycle.
  generate
    if (WORD_W == 1) begin : g_single
      assign shift_nxt = i_lfsr_bit;
    end else begin : g_multi
      logic [WORD_W-2:0] shreg;
      assign shift_nxt = {shreg, i_lfsr_bit};
      always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
          shreg <= '0;
        end else if (state == S_RUN) begin
          shreg <= shift_nxt[WORD_W-2:0];
        end
      end
    end
  endgenerate

  // FSM: state register
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM: next-state logic
  always_comb begin
    state_nxt = state;
    if (abort_go) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_start) begin
            state_nxt = (i_nwords != '0) ? S_LOAD : S_DONE;
          end
        end
        S_LOAD: begin
          if (WARMUP == 0) state_nxt = S_RUN;
          else             state_nxt = S_WARMUP;
        end
        S_WARMUP: begin
          if (warm_cnt == WARM_LAST) state_nxt = S_RUN;
        end
        S_RUN: begin
          if (bit_cnt == BIT_LAST) state_nxt = S_HOLD;
        end
        S_HOLD: begin
          if (i_ready) begin
            state_nxt = (words_left == CNT_W'(1)) ? S_DONE : S_RUN;
          end
        end
        S_DONE:  state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // FSM: outputs decoded from the registered state. Load and step are
  // decoded from different states, so they can never be high together.
  always_comb begin
    o_lfsr_load = 1'b0;
    o_lfsr_step = 1'b0;
    o_busy      = 1'b1;
    o_done      = 1'b0;
    case (state)
      S_IDLE:   o_busy      = 1'b0;
      S_LOAD:   o_lfsr_load = 1'b1;
      S_WARMUP: o_lfsr_step = 1'b1;
      S_RUN:    o_lfsr_step = 1'b1;
      S_DONE:   o_done      = 1'b1;
      default:  ;
    endcase
  end

  // Datapath: seed, counters, and the output word.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      seed_q     <= '0;
      words_left <= '0;
      warm_cnt   <= '0;
      bit_cnt    <= '0;
      word_q     <= '0;
      valid_q    <= 1'b0;
    end else if (abort_go) begin
      valid_q    <= 1'b0;
      warm_cnt   <= '0;
      bit_cnt    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_start && (i_nwords != '0)) begin
            seed_q     <= seed_latch;
            words_left <= i_nwords;
          end
        end
        S_LOAD: begin
          warm_cnt <= '0;
          bit_cnt  <= '0;
        end
        S_WARMUP: warm_cnt <= warm_cnt + 10'd1;
        S_RUN: begin
          if (bit_cnt == BIT_LAST) begin
            bit_cnt <= '0;
            word_q  <= shift_nxt;
            valid_q <= 1'b1;
          end else begin
            bit_cnt <= bit_cnt + BIT_W'(1);
          end
        end
        S_HOLD: begin
          if (i_ready) begin
            valid_q    <= 1'b0;
            words_left <= words_left - CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign o_lfsr_seed = seed_q;
  assign o_word      = word_q;
  assign o_valid     = valid_q;
  assign o_state     = state;

endmodule
